// File: rtl/ifetch_buffer.sv
// Instruction fetch front end: issues in-order word reads, buffers returned words with
// their PC in a small FIFO for decode, and flushes/drops stale responses on redirect.
module ifetch_buffer #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_mem_req_valid,
    input  logic        i_mem_req_ready,
    output logic [31:0] o_mem_req_addr,
    input  logic        i_mem_rsp_valid,
    input  logic [31:0] i_mem_rsp_data,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    output logic        o_inst_trap,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_TRAP = 1'b1;

    logic [0:0]       state;
    logic [31:0]      fpc;
    logic [CW-1:0]    pending;
    logic [CW-1:0]    drop;
    logic [CW-1:0]    count;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [PW-1:0]    fill;
    logic [DEPTH-1:0] ent_dv;
    logic [DEPTH-1:0] ent_trap;
    logic [31:0]      ent_pc   [DEPTH];
    logic [31:0]      ent_data [DEPTH];

    logic req_fire;
    logic pop;
    logic rsp_live;
    logic rsp_drop;
    logic rsp_fill;
    logic redir_trap;

    // Gating with i_rst_n keeps the request port quiet while reset is held.
    assign o_mem_req_valid = i_rst_n && (state == ST_RUN) && (count < CW'(DEPTH))
                             && !i_redirect_valid;
    assign o_mem_req_addr  = i_rst_n ? fpc : '0;

    assign o_inst_valid = (count != '0) && ent_dv[head];
    assign o_inst_trap  = o_inst_valid && ent_trap[head];
    assign o_inst       = (o_inst_valid && !ent_trap[head]) ? ent_data[head] : '0;
    assign o_inst_pc    = o_inst_valid ? ent_pc[head] : '0;

    assign req_fire   = o_mem_req_valid && i_mem_req_ready;
    assign pop        = o_inst_valid && i_inst_ready;
    assign rsp_live   = i_mem_rsp_valid && ((drop != '0) || (pending != '0));
    assign rsp_drop   = i_mem_rsp_valid && (drop != '0);
    assign rsp_fill   = i_mem_rsp_valid && (drop == '0) && (pending != '0);
    assign redir_trap = i_redirect_valid && (i_redirect_pc[1:0] != 2'b00);

    // NOTE: state registers use non-blocking assignments so every update in this block
    // sees the pre-edge values of its neighbours.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_RUN;
            fpc      <= RESET_ADDR;
            pending  <= '0;
            drop     <= '0;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            fill     <= '0;
            ent_dv   <= '0;
            ent_trap <= '0;
        end else if (i_redirect_valid) begin
            // Everything still outstanding becomes stale, less a response landing now.
            head    <= '0;
            fill    <= '0;
            pending <= '0;
            drop    <= drop + pending - CW'(rsp_live);
            fpc     <= i_redirect_pc;
            if (redir_trap) begin
                state    <= ST_TRAP;
                tail     <= PW'(1);
                count    <= CW'(1);
                ent_dv   <= DEPTH'(1);
                ent_trap <= DEPTH'(1);
            end else begin
                state    <= ST_RUN;
                tail     <= '0;
                count    <= '0;
                ent_dv   <= '0;
                ent_trap <= '0;
            end
        end else begin
            if (req_fire) begin
                tail           <= tail + PW'(1);
                fpc            <= fpc + 32'd4;
                ent_dv[tail]   <= 1'b0;
                ent_trap[tail] <= 1'b0;
            end
            if (rsp_fill) begin
                ent_dv[fill] <= 1'b1;
                fill         <= fill + PW'(1);
            end
            if (rsp_drop) begin
                drop <= drop - CW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            pending <= pending + CW'(req_fire) - CW'(rsp_fill);
            count   <= count + CW'(req_fire) - CW'(pop);
        end
    end

    // NOTE: payload storage carries no reset; count and ent_dv gate every read of it.
    always_ff @(posedge i_clk) begin
        if (i_redirect_valid) begin
            if (redir_trap) begin
                ent_pc[0]   <= i_redirect_pc;
                ent_data[0] <= '0;
            end
        end else begin
            if (req_fire) begin
                ent_pc[tail] <= fpc;
            end
            if (rsp_fill) begin
                ent_data[fill] <= i_mem_rsp_data;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_buffer.sv
// Self-checking bench for ifetch_buffer: in-order memory model with variable latency,
// scoreboard of expected decode entries, a redirect vector table and hand-written corners.
module tb_ifetch_buffer;
    localparam logic [31:0] RESET_ADDR = 32'h0000_0100;
    localparam int          DEPTH      = 4;

    logic        i_clk;
    logic        i_rst_n;
    logic        o_mem_req_valid;
    logic        i_mem_req_ready;
    logic [31:0] o_mem_req_addr;
    logic        i_mem_rsp_valid;
    logic [31:0] i_mem_rsp_data;
    logic        o_inst_valid;
    logic        i_inst_ready;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        o_inst_trap;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;

    ifetch_buffer #(.RESET_ADDR(RESET_ADDR), .DEPTH(DEPTH)) dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .o_mem_req_valid (o_mem_req_valid),
        .i_mem_req_ready (i_mem_req_ready),
        .o_mem_req_addr  (o_mem_req_addr),
        .i_mem_rsp_valid (i_mem_rsp_valid),
        .i_mem_rsp_data  (i_mem_rsp_data),
        .o_inst_valid    (o_inst_valid),
        .i_inst_ready    (i_inst_ready),
        .o_inst          (o_inst),
        .o_inst_pc       (o_inst_pc),
        .o_inst_trap     (o_inst_trap),
        .i_redirect_valid(i_redirect_valid),
        .i_redirect_pc   (i_redirect_pc)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        trap;
    } exp_t;

    typedef struct {
        logic [31:0] target;
        int          lat;
        int          run;
        logic        exp_trap;
        logic [31:0] exp_inst;
        logic        exp_req;
    } redir_vec_t;

    mem_req_t    mem_q[$];
    exp_t        exp_q[$];
    exp_t        last_pop;
    redir_vec_t  vecs[5];
    int          total;
    int          bad;
    int          cyc;
    int          lat;
    int          n_req;
    int          n_pop;
    logic [31:0] exp_fpc;
    logic [31:0] last_req_addr;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: memory drives its response, handshakes are scored, then advance.
    task automatic cycle();
        exp_t e;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
            i_mem_rsp_valid = 1'b1;
            i_mem_rsp_data  = word_at(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            i_mem_rsp_valid = 1'b0;
            i_mem_rsp_data  = '0;
        end
        #1;
        if (i_rst_n) begin
            if (i_redirect_valid) check("req_during_redirect", 32'(o_mem_req_valid), 32'd0);
            if (o_mem_req_valid && i_mem_req_ready) begin
                check("req_addr", o_mem_req_addr, exp_fpc);
                mem_q.push_back('{o_mem_req_addr, cyc + lat});
                exp_q.push_back('{o_mem_req_addr, word_at(o_mem_req_addr), 1'b0});
                exp_fpc       = exp_fpc + 32'd4;
                last_req_addr = o_mem_req_addr;
                n_req++;
            end
            if (o_inst_valid && i_inst_ready) begin
                last_pop = '{o_inst_pc, o_inst, o_inst_trap};
                n_pop++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_unexpected: got pc %h, want no entry (cycle %0d)", o_inst_pc, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_pc", o_inst_pc, e.pc);
                    check("pop_inst", o_inst, e.inst);
                    check("pop_trap", 32'(o_inst_trap), 32'(e.trap));
                end
            end
            if (i_redirect_valid) begin
                exp_q.delete();
                if (i_redirect_pc[1:0] != 2'b00) exp_q.push_back('{i_redirect_pc, 32'h0, 1'b1});
                exp_fpc = i_redirect_pc;
            end
        end
        @(posedge i_clk);
        @(negedge i_clk);
        cyc++;
    endtask

    task automatic wait_pop(input string name, input int max);
        int base;
        int k;
        base = n_pop;
        k    = 0;
        while (n_pop == base && k < max) begin
            cycle();
            k++;
        end
        if (n_pop == base) begin
            total++;
            bad++;
            $display("FAIL %s: no instruction within %0d cycles", name, max);
        end
    endtask

    task automatic wait_req(input string name, input int max);
        int base;
        int k;
        base = n_req;
        k    = 0;
        while (n_req == base && k < max) begin
            cycle();
            k++;
        end
        if (n_req == base) begin
            total++;
            bad++;
            $display("FAIL %s: no request within %0d cycles", name, max);
        end
    endtask

    // Called at a negedge: assert reset, check outputs drop at once, hold, release.
    task automatic do_reset(input int hold);
        i_rst_n = 1'b0;
        #1;
        check("rst_req_valid", 32'(o_mem_req_valid), 32'd0);
        check("rst_req_addr", o_mem_req_addr, 32'd0);
        check("rst_inst_valid", 32'(o_inst_valid), 32'd0);
        check("rst_inst", o_inst, 32'd0);
        check("rst_inst_pc", o_inst_pc, 32'd0);
        check("rst_inst_trap", 32'(o_inst_trap), 32'd0);
        exp_q.delete();
        exp_fpc = RESET_ADDR;
        repeat (hold) cycle();
        i_rst_n = 1'b1;
    endtask

    initial begin
        int base;

        vecs[0] = '{32'h0000_0200, 3, 6, 1'b0, word_at(32'h0000_0200), 1'b1};
        vecs[1] = '{32'h0000_0202, 1, 4, 1'b1, 32'h0000_0000,          1'b0};
        vecs[2] = '{32'h0000_0206, 1, 3, 1'b1, 32'h0000_0000,          1'b0};
        vecs[3] = '{32'h0000_0300, 1, 2, 1'b0, word_at(32'h0000_0300), 1'b1};
        vecs[4] = '{32'hFFFF_FFF8, 2, 3, 1'b0, word_at(32'hFFFF_FFF8), 1'b1};

        total = 0; bad = 0; cyc = 0; lat = 1; n_req = 0; n_pop = 0;
        exp_fpc = RESET_ADDR; last_req_addr = '0; last_pop = '{32'h0, 32'h0, 1'b0};
        i_rst_n = 1'b0; i_mem_req_ready = 1'b1; i_mem_rsp_valid = 1'b0; i_mem_rsp_data = '0;
        i_inst_ready = 1'b0; i_redirect_valid = 1'b0; i_redirect_pc = '0;
        @(negedge i_clk);

        // Reset state, then streaming from RESET_ADDR at one word per cycle.
        do_reset(2);
        #1;
        check("t1_first_req_valid", 32'(o_mem_req_valid), 32'd1);
        check("t1_first_req_addr", o_mem_req_addr, RESET_ADDR);
        i_inst_ready = 1'b1;
        repeat (8) cycle();
        base = n_pop;
        repeat (8) cycle();
        check("t1_throughput", 32'(n_pop - base), 32'd8);

        // Random handshake pressure on both ports.
        lat = 2;
        for (int i = 0; i < 40; i++) begin
            i_mem_req_ready = 1'($urandom_range(0, 1));
            i_inst_ready    = 1'($urandom_range(0, 1));
            cycle();
        end
        i_mem_req_ready = 1'b1;
        i_inst_ready    = 1'b1;

        // Decode stalled: exactly DEPTH requests, then drain and resume at +4*DEPTH.
        do_reset(1);
        lat = 1;
        i_inst_ready = 1'b0;
        base = n_req;
        repeat (12) cycle();
        check("t2_req_count", 32'(n_req - base), 32'(DEPTH));
        check("t2_req_blocked", 32'(o_mem_req_valid), 32'd0);
        i_inst_ready = 1'b1;
        wait_pop("t2_first_pop", 4);
        check("t2_first_pc", last_pop.pc, RESET_ADDR);
        wait_req("t2_resume", 8);
        check("t2_resume_addr", last_req_addr, RESET_ADDR + 32'h10);

        // Redirect table: aligned, misaligned (trap), trap->trap, trap->run, address wrap.
        for (int i = 0; i < 5; i++) begin
            lat = vecs[i].lat;
            repeat (vecs[i].run) cycle();
            i_redirect_valid = 1'b1;
            i_redirect_pc    = vecs[i].target;
            cycle();
            i_redirect_valid = 1'b0;
            i_redirect_pc    = '0;
            wait_pop($sformatf("v%0d_first", i), 30);
            check($sformatf("v%0d_pc", i), last_pop.pc, vecs[i].target);
            check($sformatf("v%0d_trap", i), 32'(last_pop.trap), 32'(vecs[i].exp_trap));
            check($sformatf("v%0d_inst", i), last_pop.inst, vecs[i].exp_inst);
            base = n_req;
            repeat (6) cycle();
            check($sformatf("v%0d_req_after", i), 32'(n_req != base), 32'(vecs[i].exp_req));
        end

        // Redirect coinciding with a response and a decode handshake.
        lat = 1;
        repeat (6) cycle();
        base = n_pop;
        i_redirect_valid = 1'b1;
        i_redirect_pc    = 32'h0000_0500;
        cycle();
        i_redirect_valid = 1'b0;
        i_redirect_pc    = '0;
        check("t5_pop_in_redirect", 32'(n_pop - base), 32'd1);
        wait_pop("t5_first", 10);
        check("t5_pc", last_pop.pc, 32'h0000_0500);
        check("t5_inst", last_pop.inst, word_at(32'h0000_0500));

        // Reset mid-run with requests in flight; late responses must not land.
        lat = 2;
        repeat (6) cycle();
        do_reset(1);
        #1;
        check("t6_restart_addr", o_mem_req_addr, RESET_ADDR);
        wait_pop("t6_first", 10);
        check("t6_pc", last_pop.pc, RESET_ADDR);
        check("t6_inst", last_pop.inst, word_at(RESET_ADDR));
        repeat (8) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
